// File: rtl/fetch_decode.sv
// fetch_decode: 16 x 16-bit register file for the decode stage.
// Two registered read ports with write-first bypass and one registered write
// port that echoes the written value on writeout. On reset, each register is
// loaded with its own index.
module fetch_decode #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read1,
  input  logic [ADDR_W-1:0] read2,
  input  logic [ADDR_W-1:0] write,
  input  logic              readEnable,
  input  logic              writeEnable,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] readout1,
  output logic [DATA_W-1:0] readout2,
  output logic [DATA_W-1:0] writeout
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] rd1_val;
  logic [DATA_W-1:0] rd2_val;

  // Read data with write-first bypass, resolved independently per port
  always_comb begin
    rd1_val = regs[read1];
    rd2_val = regs[read2];
    if (writeEnable && (write == read1)) rd1_val = data;
    if (writeEnable && (write == read2)) rd2_val = data;
  end

  // Register array: reset loads index pattern, otherwise write port updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= DATA_W'(i);
    end else if (writeEnable) begin
      regs[write] <= data;
    end
  end

  // Registered read outputs, held when reads are disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readout1 <= '0;
      readout2 <= '0;
    end else if (readEnable) begin
      readout1 <= rd1_val;
      readout2 <= rd2_val;
    end
  end

  // Echo of the last written value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      writeout <= '0;
    end else if (writeEnable) begin
      writeout <= data;
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Testbench for fetch_decode: a reference model computes the expected outputs
// as stimulus is driven, pushes them onto a queue, and compares them after
// each clock edge.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  read1, read2, write;
  logic        readEnable, writeEnable;
  logic [15:0] data;
  logic [15:0] readout1, readout2, writeout;

  fetch_decode #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .read1(read1), .read2(read2), .write(write),
    .readEnable(readEnable), .writeEnable(writeEnable), .data(data),
    .readout1(readout1), .readout2(readout2), .writeout(writeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] wo;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mregs [16];
  logic [15:0] m_r1, m_r2, m_wo;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = 16'(i);
    m_r1 = '0;
    m_r2 = '0;
    m_wo = '0;
  endtask

  task automatic compare_outputs(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_r1"}, readout1, e.r1);
      check({tag, "_r2"}, readout2, e.r2);
      check({tag, "_wo"}, writeout, e.wo);
    end
  endtask

  // One clock cycle: drive at negedge, update the model, compare after posedge
  task automatic cycle(input string tag, input logic re, input logic we,
                       input logic [3:0] r1, input logic [3:0] r2,
                       input logic [3:0] w, input logic [15:0] d);
    exp_t e;
    @(negedge clk);
    readEnable  = re;
    writeEnable = we;
    read1 = r1;
    read2 = r2;
    write = w;
    data  = d;
    if (!reset) begin
      if (we) begin
        mregs[w] = d;
        m_wo     = d;
      end
      if (re) begin
        m_r1 = mregs[r1];
        m_r2 = mregs[r2];
      end
    end
    e.r1 = m_r1;
    e.r2 = m_r2;
    e.wo = m_wo;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_outputs(tag);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    readEnable = 1'b0;
    writeEnable = 1'b0;
    read1 = '0;
    read2 = '0;
    write = '0;
    data  = '0;
    model_reset();

    // Edges during reset must be ignored, even with both enables high
    cycle("in_reset", 1'b1, 1'b1, 4'd3, 4'd4, 4'd3, 16'hFFFF);
    cycle("in_reset", 1'b1, 1'b1, 4'd7, 4'd8, 4'd0, 16'h1234);

    @(negedge clk);
    reset = 1'b0;
    readEnable = 1'b0;
    writeEnable = 1'b0;

    // Reset pattern: every register holds its own index
    for (int i = 0; i < 16; i++)
      cycle("reset_pat", 1'b1, 1'b0, 4'(i), 4'(15 - i), 4'd0, 16'h0);

    cycle("basic_read", 1'b1, 1'b0, 4'd2, 4'd3, 4'd0, 16'h0);
    cycle("wr_no_rd", 1'b0, 1'b1, 4'd9, 4'd9, 4'd6, 16'd143);
    cycle("readback6", 1'b1, 1'b0, 4'd6, 4'd6, 4'd0, 16'h0);
    cycle("bypass", 1'b1, 1'b1, 4'd5, 4'd6, 4'd5, 16'hBEEF);
    cycle("bypass_both", 1'b1, 1'b1, 4'd9, 4'd9, 4'd9, 16'h5A5A);

    // Hold: both enables low while every other input changes
    for (int i = 0; i < 3; i++)
      cycle("hold", 1'b0, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom));
    cycle("post_hold", 1'b1, 1'b0, 4'd5, 4'd6, 4'd0, 16'h0);

    // R0 is an ordinary writable register
    cycle("r0_write", 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 16'h1234);
    cycle("r0_read", 1'b1, 1'b0, 4'd0, 4'd15, 4'd0, 16'h0);

    // Randomised traffic against the model
    for (int i = 0; i < 40; i++)
      cycle("rand", 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
            4'($urandom), 16'($urandom));

    // Mid-cycle asynchronous reset with a write pending
    cycle("pre_areset", 1'b1, 1'b1, 4'd6, 4'd1, 4'd6, 16'd143);
    @(negedge clk);
    readEnable = 1'b1;
    writeEnable = 1'b1;
    write = 4'd6;
    data = 16'hAAAA;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    e.r1 = m_r1;
    e.r2 = m_r2;
    e.wo = m_wo;
    sb.push_back(e);
    compare_outputs("areset_now");
    cycle("areset_edge", 1'b1, 1'b1, 4'd6, 4'd6, 4'd6, 16'hAAAA);
    @(negedge clk);
    reset = 1'b0;
    readEnable = 1'b0;
    writeEnable = 1'b0;
    cycle("after_areset", 1'b1, 1'b0, 4'd6, 4'd2, 4'd0, 16'h0);

    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
